bubble_access_sequencer: RTL and testbench
==========================================

# bubble_access_sequencer

Sequences emulated bubble-memory accesses for BubbleDrive8. Watches the host strobes nBSEN, nREPEN and nBOOTEN. Tracks the current bubble loop position from shift periods and turns each replicator pulse into a page-load request to the page buffer loader, which fetches from SPI flash. Sits between the host-side input pins and the flash/page-buffer datapath, and also drives the access LED.

## Interface
Parameters:
- POSITIONS, 2053: bubble loop positions per revolution; position counter wraps POSITIONS-1 -> 0.
- SHIFT_DIV, 120: MCLK cycles per bubble shift period (minimum 4).
- BOOT_PAGES, 128: boot-loop page count in bootloop mode.

Ports:
- MCLK  in  1  system clock.
- nMRST  in  1  asynchronous, active-low reset.
- nBSEN  in  1  bubble shift enable from host, async, active low.
- nREPEN  in  1  replicator enable from host, async, active low.
- nBOOTEN  in  1  boot-loop select, async; low = bootloop mode, high = user mode.
- LOAD_ACK  in  1  page loader acknowledge, MCLK-synchronous.
- LOAD_REQ  out  1  page-load request.
- LOAD_PAGE  out  12  page number; stable while LOAD_REQ = 1.
- LOAD_BOOT  out  1  1 = LOAD_PAGE is a boot-loop page.
- SHIFT_TICK  out  1  one-cycle pulse per bubble shift period.
- POSITION  out  12  current loop position.
- OVERRUN  out  1  sticky: a replicate occurred while a request was pending.
- nLED_ACC  out  1  access LED, active low.

## Operation
- All three host inputs pass through a 2-FF synchronizer, then a 1-FF edge-detect register.
- States:
  - IDLE:
    - Synchronized nBSEN falls -> SHIFTING.
    - Divider cleared.
  - SHIFTING:
    - Divider counts 0..SHIFT_DIV-1.
    - At SHIFT_DIV-1: SHIFT_TICK = 1; POSITION increments modulo POSITIONS.
    - Synchronized nBSEN rises -> IDLE. Divider cleared; POSITION held.
  - REQUEST:
    - Entered from SHIFTING on a synchronized nREPEN falling edge.
    - LOAD_REQ = 1.
    - Shifting continues: divider, ticks and POSITION keep running.
    - LOAD_ACK = 1 sampled -> LOAD_REQ drops next cycle.
    - Return to SHIFTING, or to IDLE if nBSEN is high by then.
- Page selection, latched on the replicate edge:
  - User mode (nBOOTEN high): LOAD_PAGE = POSITION; LOAD_BOOT = 0.
  - Bootloop mode: LOAD_PAGE = boot counter; LOAD_BOOT = 1. Boot counter increments modulo BOOT_PAGES after each accepted request.
  - Boot counter clears whenever synchronized nBOOTEN is high.
- nREPEN falling edge while in IDLE: ignored (no shift in progress).
- Replicate edge while in REQUEST: OVERRUN set, request dropped, boot counter not advanced. OVERRUN clears only on reset.
- Replicate edge and SHIFT_TICK in the same cycle: the latched page is the pre-increment POSITION.
- LOAD_ACK outside REQUEST: ignored.
- nLED_ACC = 0 while state != IDLE.

## Timing
- Reset values:
  - State IDLE; LOAD_REQ 0; LOAD_PAGE 0; LOAD_BOOT 0.
  - SHIFT_TICK 0; POSITION 0; OVERRUN 0; nLED_ACC 1.
  - Boot counter 0; synchronizers 1.
- Latency, pin edge to registered response:
  - nBSEN falling pin -> state SHIFTING on the 3rd MCLK edge.
  - First SHIFT_TICK SHIFT_DIV cycles after entering SHIFTING.
  - nREPEN falling pin -> LOAD_REQ high on the 3rd MCLK edge.
  - LOAD_ACK high at edge k -> LOAD_REQ low after edge k+1.
- Minimum request cycle: 2 MCLK (REQ, ACK).
- Reset mid-request: LOAD_REQ drops asynchronously. The loader aborts on LOAD_REQ low without ACK.
- POSITION wraps from POSITIONS-1 to 0 on a tick. There is no carry output.

## Configuration
- BUBBLE_ACC_STRETCH_EN defined: nLED_ACC is additionally held low for 2^20 MCLK after returning to IDLE, restarted by any new access.
- Not defined: nLED_ACC = 0 exactly while state != IDLE.

## Test plan
- Reset, then nBSEN low for 10·SHIFT_DIV+5 cycles with SHIFT_DIV=120 -> exactly 10 SHIFT_TICK pulses, POSITION = 10, nLED_ACC low; nBSEN high -> IDLE, POSITION stays 10.
- User mode, POSITION = 2052, one more tick -> POSITION = 0. Replicate after 181 ticks -> LOAD_PAGE = 181, LOAD_BOOT = 0. ACK after 5 cycles -> REQ low on the next cycle.
- Bootloop mode (nBOOTEN low), 3 replicates each acked -> LOAD_PAGE 0, 1, 2 with LOAD_BOOT = 1. nBOOTEN high then low -> next page 0. With BOOT_PAGES=128, 128 replicates -> page 127 then 0.
- Second nREPEN falling edge while LOAD_REQ is pending (ACK held low) -> OVERRUN = 1, LOAD_PAGE unchanged, boot counter unchanged.
- Replicate edge coincident with SHIFT_TICK at POSITION 40 -> LOAD_PAGE = 40, POSITION = 41.
- nMRST pulsed low mid-REQUEST -> all outputs at reset values immediately; after release, IDLE, no spurious LOAD_REQ.

Source files
------------

// File: rtl/bubble_access_sequencer_if.sv
// Page-loader handshake between the access sequencer (master) and the
// SPI-flash page buffer loader (slave).
interface bubble_access_sequencer_if;
   logic        LOAD_REQ;
   logic [11:0] LOAD_PAGE;
   logic        LOAD_BOOT;
   logic        LOAD_ACK;

   modport master (
      output LOAD_REQ,
      output LOAD_PAGE,
      output LOAD_BOOT,
      input  LOAD_ACK
   );

   modport slave (
      input  LOAD_REQ,
      input  LOAD_PAGE,
      input  LOAD_BOOT,
      output LOAD_ACK
   );
endinterface

// File: rtl/bubble_access_sequencer.sv
// Bubble access sequencer: follows the host shift/replicate/boot strobes,
// tracks the bubble loop position and issues page-load requests.
// Optional build macro BUBBLE_ACC_STRETCH_EN stretches the access LED by
// 2^20 MCLK after each access ends.
module bubble_access_sequencer #(
   parameter int unsigned POSITIONS  = 2053,
   parameter int unsigned SHIFT_DIV  = 120,
   parameter int unsigned BOOT_PAGES = 128
) (
   input  logic                              MCLK,
   input  logic                              nMRST,
   input  logic                              nBSEN,
   input  logic                              nREPEN,
   input  logic                              nBOOTEN,
   bubble_access_sequencer_if.master         ld,
   output logic                              SHIFT_TICK,
   output logic [11:0]                       POSITION,
   output logic                              OVERRUN,
   output logic                              nLED_ACC
);

   localparam int unsigned DivW     = $clog2(SHIFT_DIV);
   localparam logic [DivW-1:0] DivLast  = DivW'(SHIFT_DIV - 1);
   localparam logic [11:0]     PosLast  = 12'(POSITIONS - 1);
   localparam logic [11:0]     BootLast = 12'(BOOT_PAGES - 1);

   typedef enum logic [1:0] {StIdle, StShifting, StRequest} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic              tick_q, tick_d;
   logic [11:0]       pos_q, pos_d;
   logic [11:0]       page_q, page_d;
   logic              lboot_q, lboot_d;
   logic              ovr_q, ovr_d;
   logic [11:0]       bcnt_q, bcnt_d;

   // Host strobes: bit 0 nBSEN, bit 1 nREPEN, bit 2 nBOOTEN
   logic [2:0] sync1_q, sync2_q, prev_q;

   logic bsen_fall, bsen_high, rep_fall, boot_mode, boot_clr, advance;

   // Two-stage synchronizer followed by the edge-detect stage
   always_ff @(posedge MCLK or negedge nMRST) begin
      if (!nMRST) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
      end else begin
         sync1_q <= {nBOOTEN, nREPEN, nBSEN};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign bsen_fall = prev_q[0] & ~sync2_q[0];
   assign bsen_high = sync2_q[0];
   assign rep_fall  = prev_q[1] & ~sync2_q[1];
   assign boot_mode = ~prev_q[2];
   assign boot_clr  = prev_q[2];

   // State and datapath registers
   always_ff @(posedge MCLK or negedge nMRST) begin
      if (!nMRST) begin
         state_q <= StIdle;
         div_q   <= '0;
         tick_q  <= 1'b0;
         pos_q   <= '0;
         page_q  <= '0;
         lboot_q <= 1'b0;
         ovr_q   <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         pos_q   <= pos_d;
         page_q  <= page_d;
         lboot_q <= lboot_d;
         ovr_q   <= ovr_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Next-state: FSM transitions, shift divider, page latch and boot counter
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tick_d  = 1'b0;
      pos_d   = pos_q;
      page_d  = page_q;
      lboot_d = lboot_q;
      ovr_d   = ovr_q;
      bcnt_d  = bcnt_q;
      advance = 1'b0;

      unique case (state_q)
         StIdle: begin
            div_d = '0;
            if (bsen_fall) state_d = StShifting;
         end
         StShifting: begin
            if (bsen_high) begin
               state_d = StIdle;
            end else begin
               advance = 1'b1;
               if (rep_fall) begin
                  // pos_q is still the pre-tick value if a tick lands this cycle
                  state_d = StRequest;
                  page_d  = boot_mode ? bcnt_q : pos_q;
                  lboot_d = boot_mode;
               end
            end
         end
         StRequest: begin
            advance = 1'b1;
            // A second replicate cannot be queued; flag it and keep the pending page
            if (rep_fall) ovr_d = 1'b1;
            if (ld.LOAD_ACK) begin
               state_d = bsen_high ? StIdle : StShifting;
               if (lboot_q) bcnt_d = (bcnt_q == BootLast) ? 12'd0 : bcnt_q + 12'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if (div_q == DivLast) begin
            div_d  = '0;
            tick_d = 1'b1;
            pos_d  = (pos_q == PosLast) ? 12'd0 : pos_q + 12'd1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      if (state_d == StIdle) div_d = '0;
      if (boot_clr) bcnt_d = '0;
   end

   assign ld.LOAD_REQ  = (state_q == StRequest);
   assign ld.LOAD_PAGE = page_q;
   assign ld.LOAD_BOOT = lboot_q;
   assign SHIFT_TICK   = tick_q;
   assign POSITION     = pos_q;
   assign OVERRUN      = ovr_q;

`ifdef BUBBLE_ACC_STRETCH_EN
   logic [20:0] stretch_q;

   // Reload the hold-off while busy, count it down once idle
   always_ff @(posedge MCLK or negedge nMRST) begin
      if (!nMRST) begin
         stretch_q <= '0;
      end else if (state_q != StIdle) begin
         stretch_q <= 21'h100000;
      end else if (stretch_q != '0) begin
         stretch_q <= stretch_q - 21'd1;
      end
   end

   assign nLED_ACC = (state_q == StIdle) && (stretch_q == '0);
`else
   assign nLED_ACC = (state_q == StIdle);
`endif

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Directed bench for bubble_access_sequencer with hand-computed expectations.
// A second instance with SHIFT_DIV=4 reaches the position wrap quickly.
module tb_bubble_access_sequencer;

   logic MCLK;
   logic nMRST;
   logic nBSEN;
   logic nREPEN;
   logic nBOOTEN;
   logic nbsen_f;

   logic        SHIFT_TICK;
   logic [11:0] POSITION;
   logic        OVERRUN;
   logic        nLED_ACC;
   logic        tick_f;
   logic [11:0] pos_f;
   logic        ovr_f;
   logic        nled_f;

   int n_checks = 0;
   int n_errors = 0;
   int tick_cnt = 0;

   bubble_access_sequencer_if ld_if ();
   bubble_access_sequencer_if ldf_if ();

   bubble_access_sequencer u_dut (
      .MCLK       (MCLK),
      .nMRST      (nMRST),
      .nBSEN      (nBSEN),
      .nREPEN     (nREPEN),
      .nBOOTEN    (nBOOTEN),
      .ld         (ld_if),
      .SHIFT_TICK (SHIFT_TICK),
      .POSITION   (POSITION),
      .OVERRUN    (OVERRUN),
      .nLED_ACC   (nLED_ACC)
   );

   bubble_access_sequencer #(.SHIFT_DIV(4)) u_dut_fast (
      .MCLK       (MCLK),
      .nMRST      (nMRST),
      .nBSEN      (nbsen_f),
      .nREPEN     (nREPEN),
      .nBOOTEN    (nBOOTEN),
      .ld         (ldf_if),
      .SHIFT_TICK (tick_f),
      .POSITION   (pos_f),
      .OVERRUN    (ovr_f),
      .nLED_ACC   (nled_f)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   // Cumulative SHIFT_TICK count, sampled away from the active edge
   always @(negedge MCLK) if (SHIFT_TICK) tick_cnt = tick_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge MCLK);
      #1;
   endtask

   task automatic do_reset();
      nMRST = 1'b0;
      cyc(2);
      nMRST = 1'b1;
      cyc(2);
   endtask

   // One boot-mode replicate, acked as soon as the request is seen
   task automatic rep_ack(input int exp_page);
      nREPEN = 1'b0;
      cyc(3);
      check("rep_req", ld_if.LOAD_REQ, 1);
      check("rep_page", ld_if.LOAD_PAGE, exp_page);
      check("rep_boot", ld_if.LOAD_BOOT, 1);
      ld_if.LOAD_ACK = 1'b1;
      cyc(1);
      ld_if.LOAD_ACK = 1'b0;
      check("rep_req_drop", ld_if.LOAD_REQ, 0);
      nREPEN = 1'b1;
      cyc(3);
   endtask

   initial begin
      int t0;
      logic saw_req;
      nMRST   = 1'b1;
      nBSEN   = 1'b1;
      nREPEN  = 1'b1;
      nBOOTEN = 1'b1;
      nbsen_f = 1'b1;
      ld_if.LOAD_ACK  = 1'b0;
      ldf_if.LOAD_ACK = 1'b0;

      // Reset values
      #3 nMRST = 1'b0;
      #1;
      check("rst_req", ld_if.LOAD_REQ, 0);
      check("rst_page", ld_if.LOAD_PAGE, 0);
      check("rst_boot", ld_if.LOAD_BOOT, 0);
      check("rst_tick", SHIFT_TICK, 0);
      check("rst_pos", POSITION, 0);
      check("rst_ovr", OVERRUN, 0);
      check("rst_led", nLED_ACC, 1);
      cyc(2);
      nMRST = 1'b1;
      cyc(2);

      // Position wrap on the fast instance: tick k lands on edge 3+4k
      nbsen_f = 1'b0;
      cyc(8211);
      check("wrap_pos_last", pos_f, 2052);
      check("wrap_tick_last", tick_f, 1);
      cyc(4);
      check("wrap_pos_zero", pos_f, 0);
      check("wrap_tick_zero", tick_f, 1);
      nbsen_f = 1'b1;
      cyc(4);

      // Ten shift periods: first tick on edge 123
      t0 = tick_cnt;
      nBSEN = 1'b0;
      cyc(122);
      check("first_tick_early", tick_cnt - t0, 0);
      cyc(1);
      check("first_tick", SHIFT_TICK, 1);
      check("first_tick_pos", POSITION, 1);
      cyc(1082);
      check("ten_ticks", tick_cnt - t0, 10);
      check("ten_pos", POSITION, 10);
      check("shift_led", nLED_ACC, 0);
      nBSEN = 1'b1;
      cyc(5);
      check("idle_led", nLED_ACC, 1);
      check("idle_pos_held", POSITION, 10);
      check("idle_ticks", tick_cnt - t0, 10);

      // User-mode replicate at position 181
      do_reset();
      nBSEN = 1'b0;
      cyc(21733);
      check("user_pos", POSITION, 181);
      nREPEN = 1'b0;
      cyc(2);
      check("user_req_early", ld_if.LOAD_REQ, 0);
      cyc(1);
      check("user_req", ld_if.LOAD_REQ, 1);
      check("user_page", ld_if.LOAD_PAGE, 181);
      check("user_boot", ld_if.LOAD_BOOT, 0);
      check("req_led", nLED_ACC, 0);
      cyc(4);
      check("user_req_held", ld_if.LOAD_REQ, 1);
      ld_if.LOAD_ACK = 1'b1;
      cyc(1);
      check("user_req_drop", ld_if.LOAD_REQ, 0);
      ld_if.LOAD_ACK = 1'b0;
      nREPEN = 1'b1;
      nBSEN  = 1'b1;
      cyc(4);

      // Bootloop mode
      nBOOTEN = 1'b0;
      cyc(4);
      nBSEN = 1'b0;
      cyc(4);
      rep_ack(0);
      rep_ack(1);
      rep_ack(2);
      nBOOTEN = 1'b1;
      cyc(4);
      nBOOTEN = 1'b0;
      cyc(4);
      for (int i = 0; i < 128; i++) rep_ack(i);
      rep_ack(0);

      // Overrun: second replicate while request 1 is pending
      nREPEN = 1'b0;
      cyc(3);
      check("ovr_first_page", ld_if.LOAD_PAGE, 1);
      check("ovr_not_yet", OVERRUN, 0);
      nREPEN = 1'b1;
      cyc(3);
      nREPEN = 1'b0;
      cyc(3);
      check("ovr_set", OVERRUN, 1);
      check("ovr_req_held", ld_if.LOAD_REQ, 1);
      check("ovr_page_kept", ld_if.LOAD_PAGE, 1);
      ld_if.LOAD_ACK = 1'b1;
      cyc(1);
      ld_if.LOAD_ACK = 1'b0;
      nREPEN = 1'b1;
      cyc(3);
      rep_ack(2);
      check("ovr_sticky", OVERRUN, 1);

      // Stray ACK while shifting must not advance the boot counter
      ld_if.LOAD_ACK = 1'b1;
      cyc(3);
      ld_if.LOAD_ACK = 1'b0;
      rep_ack(3);

      // Replicate coincident with the tick that moves 40 -> 41
      nBSEN   = 1'b1;
      nBOOTEN = 1'b1;
      cyc(4);
      do_reset();
      check("ovr_cleared", OVERRUN, 0);
      nBSEN = 1'b0;
      cyc(4920);
      check("coin_pos_before", POSITION, 40);
      nREPEN = 1'b0;
      cyc(3);
      check("coin_tick", SHIFT_TICK, 1);
      check("coin_pos_after", POSITION, 41);
      check("coin_req", ld_if.LOAD_REQ, 1);
      check("coin_page", ld_if.LOAD_PAGE, 40);

      // Reset mid-request
      #2 nMRST = 1'b0;
      #1;
      check("mid_rst_req", ld_if.LOAD_REQ, 0);
      check("mid_rst_page", ld_if.LOAD_PAGE, 0);
      check("mid_rst_pos", POSITION, 0);
      check("mid_rst_led", nLED_ACC, 1);
      nBSEN  = 1'b1;
      nREPEN = 1'b1;
      cyc(2);
      nMRST = 1'b1;
      saw_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (ld_if.LOAD_REQ) saw_req = 1'b1;
      end
      check("post_rst_no_req", saw_req, 0);
      check("post_rst_led", nLED_ACC, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
